psx_pad_responder: RTL
======================

# psx_pad_responder

Controller-side emulator that answers the PSX host's polling transaction. Watches the host's att/psx_clk/cmd lines and returns a standard 5-byte digital-pad reply on data, with an ack pulse after each non-final byte. The reply is 0xFF, 0x41, 0x5A, buttons[7:0], buttons[15:8]. Sits directly downstream of the host poller on the pad bus, in place of a physical controller, so the host can be exercised on-chip.

## Interface
- SYNC_STAGES, 2: flops per input synchronizer, minimum 2.
- ACK_DELAY, 2: clk cycles from a byte's 8th psx_clk rising edge to ack falling.
- ACK_WIDTH, 4: clk cycles ack is held low.
- PAD_ID, 8'h41: byte returned in slot 1.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- att  in  1  host attention; low for the whole transaction.
- psx_clk  in  1  host shift clock, idle high.
- cmd  in  1  host command bit, LSB-first.
- buttons  in  16  pad button state, active-low (0 = pressed).
- data  out  1  reply bit to host, LSB-first, idle high.
- ack  out  1  byte acknowledge, active-low pulse, idle high.

## Operation
- att, psx_clk and cmd pass through SYNC_STAGES-flop synchronizers. Edges are detected on the synchronized values only.
- States: IDLE, SHIFT, ACK_WAIT, ACK_PULSE, DONE.
- IDLE, on a synchronized att fall:
  - snapshot buttons into a 16-bit latch;
  - load byte index 0 and tx byte 0xFF, bit count 0;
  - go to SHIFT.
- SHIFT, on a psx_clk fall: drive data = tx[bit]. This is the first thing that happens in the state.
- SHIFT, on a psx_clk rise:
  - shift cmd into the rx register;
  - increment the 3-bit bit count.
- After the 8th rise:
  - if byte index < 4: go to ACK_WAIT.
  - if byte index = 4: go to DONE.
- ACK_WAIT, after ACK_DELAY clk: drive ack low and go to ACK_PULSE.
- ACK_PULSE, after ACK_WIDTH clk:
  - release ack;
  - increment byte index and load the next tx byte (PAD_ID, 0x5A, latch[7:0], latch[15:8]);
  - go to SHIFT.
- A psx_clk fall during ACK_WAIT or ACK_PULSE is not lost. It is recorded, and bit 0 of the next byte is driven on entry to SHIFT. The ack pulse always completes its full width.
- DONE: hold data=1 and ack=1 until att rises.
- A synchronized att rise in any state forces IDLE within 1 clk, with data=1, ack=1 and bit count cleared. This includes a mid-byte rise.
- The buttons latch does not change during a transaction.

## Timing
- Reset values: data=1, ack=1, state IDLE, latch 16'hFFFF, all synchronizers 1.
- Pin-to-output latency from a psx_clk fall to data valid is SYNC_STAGES+1 clk.
- The ack low edge occurs SYNC_STAGES+1+ACK_DELAY clk after the 8th psx_clk rise at the pin.
- Required clk frequency: at least 8× psx_clk and at least 4× the shortest att-high interval. The block does not detect violations.
- Simultaneous psx_clk edge and att rise: the att rise wins.
- rst_n asserted mid-transaction: outputs return to reset values immediately (asynchronously).

## Configuration
- PSX_PAD_CMD_CHECK_EN defined:
  - The rx byte is compared at the end of byte 0 (must be 0x01) and byte 1 (must be 0x42).
  - On a mismatch: no ack, go to DONE, data=1 until att rises.
- PSX_PAD_CMD_CHECK_EN undefined: cmd is synchronized but ignored, and the rx register is not built.

## Structure
- Package psx_pad_pkg contains:
  - the state enum;
  - the constants PSX_START=8'h01, PSX_POLL=8'h42, PSX_IDLE_BYTE=8'hFF, PSX_READY=8'h5A, PSX_XFER_BYTES=5.
- Sub-module psx_edge_sync: a SYNC_STAGES synchronizer with rise/fall strobes, instanced for att and psx_clk. cmd uses its level output only.

## Test plan
- Full poll, buttons=16'hFFFE, host sends 0x01, 0x42, 0x00, 0x00, 0x00 → data bytes 0xFF, 0x41, 0x5A, 0xFE, 0xFF; exactly 4 ack pulses, each ACK_WIDTH clk long; no ack after byte 4.
- buttons changed from 16'h1234 to 16'h0000 mid-transaction → reply is 0x34, 0x12 (latched values).
- att raised after 3 bits of byte 2 → within SYNC_STAGES+1 clk: data=1, ack=1, IDLE. A following full poll returns correct bytes.
- Host clocks byte 1 bit 0 during ack low → bit 0 of 0x41 (1) is driven on entry to SHIFT, and byte 1 reads 0x41.
- With PSX_PAD_CMD_CHECK_EN, host sends 0x81 first → no ack, data stays 1 through all 40 clocks. Without the macro → normal 5-byte reply.
- rst_n pulsed low mid-byte 3 → data=1, ack=1 asynchronously. After release, the block waits for a new att fall.

Source files
------------

// File: rtl/psx_pad_pkg.sv
// Shared types and constants for the PSX digital-pad responder.
`timescale 1ns/1ps
package psx_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ACK_WAIT,
        ACK_PULSE,
        DONE
    } psx_state_e;

    localparam logic [7:0] PSX_START      = 8'h01;
    localparam logic [7:0] PSX_POLL       = 8'h42;
    localparam logic [7:0] PSX_IDLE_BYTE  = 8'hFF;
    localparam logic [7:0] PSX_READY      = 8'h5A;
    localparam int         PSX_XFER_BYTES = 5;

    // Reply byte for a given slot of the 5-byte digital-pad answer.
    function automatic logic [7:0] psx_reply_byte(input logic [2:0]  idx,
                                                  input logic [7:0]  pad_id,
                                                  input logic [15:0] btn);
        case (idx)
            3'd0:    return PSX_IDLE_BYTE;
            3'd1:    return pad_id;
            3'd2:    return PSX_READY;
            3'd3:    return btn[7:0];
            default: return btn[15:8];
        endcase
    endfunction

endpackage

// File: rtl/psx_edge_sync.sv
// Multi-flop input synchronizer with rise/fall strobes on the synchronized level.
// Everything resets to 1 so idle-high pad lines produce no spurious edges.
`timescale 1ns/1ps
module psx_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              q_d;

    // Shift the raw pin through the chain and keep the previous synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            q_d  <= 1'b1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            q_d  <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/psx_pad_responder.sv
// PSX digital-pad emulator: answers a host poll with FF, PAD_ID, 5A, buttons lo, buttons hi.
// Optional feature: define PSX_PAD_CMD_CHECK_EN to verify the host's 0x01/0x42 header
// and refuse to answer (no ack, data held high) when it does not match.
`timescale 1ns/1ps
module psx_pad_responder
    import psx_pad_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         ACK_DELAY   = 2,
    parameter int         ACK_WIDTH   = 4,
    parameter logic [7:0] PAD_ID      = 8'h41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        att,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack
);

    localparam logic [7:0] DLY_LAST  = 8'(ACK_DELAY - 1);
    localparam logic [7:0] WID_LAST  = 8'(ACK_WIDTH - 1);
    localparam logic [2:0] BYTE_LAST = 3'(PSX_XFER_BYTES - 1);

    logic att_q, att_rise, att_fall;
    logic pclk_q, pclk_rise, pclk_fall;
    logic cmd_s, cmd_rise, cmd_fall;

    psx_edge_sync #(.STAGES(SYNC_STAGES)) u_att_sync (
        .clk(clk), .rst_n(rst_n), .d(att),
        .q(att_q), .rise(att_rise), .fall(att_fall)
    );

    psx_edge_sync #(.STAGES(SYNC_STAGES)) u_pclk_sync (
        .clk(clk), .rst_n(rst_n), .d(psx_clk),
        .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall)
    );

    psx_edge_sync #(.STAGES(SYNC_STAGES)) u_cmd_sync (
        .clk(clk), .rst_n(rst_n), .d(cmd),
        .q(cmd_s), .rise(cmd_rise), .fall(cmd_fall)
    );

    psx_state_e  state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [2:0]  byte_idx, byte_idx_n;
    logic [7:0]  tx, tx_n;
    logic [15:0] latch, latch_n;
    logic [7:0]  tmr, tmr_n;
    logic        pend, pend_n;     // psx_clk fall seen while ack handshake is in progress
    logic        data_n, ack_n;

`ifdef PSX_PAD_CMD_CHECK_EN
    logic [7:0]  rx, rx_n;
    logic        unused_sync;
    assign unused_sync = &{1'b0, att_q, pclk_q, cmd_rise, cmd_fall};
`else
    logic        unused_sync;
    assign unused_sync = &{1'b0, att_q, pclk_q, cmd_s, cmd_rise, cmd_fall};
`endif

    // State and datapath registers; outputs are registered so reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_idx <= '0;
            tx       <= PSX_IDLE_BYTE;
            latch    <= 16'hFFFF;
            tmr      <= '0;
            pend     <= 1'b0;
            data     <= 1'b1;
            ack      <= 1'b1;
`ifdef PSX_PAD_CMD_CHECK_EN
            rx       <= '0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            byte_idx <= byte_idx_n;
            tx       <= tx_n;
            latch    <= latch_n;
            tmr      <= tmr_n;
            pend     <= pend_n;
            data     <= data_n;
            ack      <= ack_n;
`ifdef PSX_PAD_CMD_CHECK_EN
            rx       <= rx_n;
`endif
        end
    end

    // Next-state and output decode; an att rise overrides everything else.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        byte_idx_n = byte_idx;
        tx_n       = tx;
        latch_n    = latch;
        tmr_n      = tmr;
        pend_n     = pend;
        data_n     = data;
        ack_n      = ack;
`ifdef PSX_PAD_CMD_CHECK_EN
        rx_n       = rx;
`endif

        if (att_rise) begin
            state_n   = IDLE;
            data_n    = 1'b1;
            ack_n     = 1'b1;
            bit_cnt_n = '0;
            pend_n    = 1'b0;
            tmr_n     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (att_fall) begin
                        latch_n    = buttons;
                        byte_idx_n = '0;
                        tx_n       = PSX_IDLE_BYTE;
                        bit_cnt_n  = '0;
                        pend_n     = 1'b0;
                        state_n    = SHIFT;
                    end
                end

                SHIFT: begin
                    if (pclk_fall)
                        data_n = tx[bit_cnt];
                    if (pclk_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
`ifdef PSX_PAD_CMD_CHECK_EN
                        rx_n = {cmd_s, rx[7:1]};
`endif
                        if (bit_cnt == 3'd7) begin
                            tmr_n = '0;
                            if (byte_idx == BYTE_LAST) begin
                                state_n = DONE;
                                data_n  = 1'b1;
                            end else begin
                                state_n = ACK_WAIT;
                            end
`ifdef PSX_PAD_CMD_CHECK_EN
                            // Bad header: stay silent for the rest of the transaction.
                            if ((byte_idx == 3'd0 && rx_n != PSX_START) ||
                                (byte_idx == 3'd1 && rx_n != PSX_POLL)) begin
                                state_n = DONE;
                                data_n  = 1'b1;
                            end
`endif
                        end
                    end
                end

                ACK_WAIT: begin
                    if (pclk_fall)
                        pend_n = 1'b1;
                    if (tmr == DLY_LAST) begin
                        ack_n   = 1'b0;
                        tmr_n   = '0;
                        state_n = ACK_PULSE;
                    end else begin
                        tmr_n = tmr + 8'd1;
                    end
                end

                ACK_PULSE: begin
                    if (pclk_fall)
                        pend_n = 1'b1;
                    if (tmr == WID_LAST) begin
                        ack_n      = 1'b1;
                        tmr_n      = '0;
                        byte_idx_n = byte_idx + 3'd1;
                        tx_n       = psx_reply_byte(byte_idx_n, PAD_ID, latch);
                        state_n    = SHIFT;
                        // Host already dropped psx_clk for bit 0: present it now.
                        if (pend || pclk_fall) begin
                            data_n = tx_n[0];
                            pend_n = 1'b0;
                        end
                    end else begin
                        tmr_n = tmr + 8'd1;
                    end
                end

                DONE: begin
                    data_n = 1'b1;
                    ack_n  = 1'b1;
                end

                default: state_n = IDLE;
            endcase
        end
    end

endmodule
